// File: rtl/riscv_dmem_mmio.sv
`timescale 1ns/1ps
// riscv_dmem_mmio: zero-latency data memory below the RV32I MEM stage.
// Byte-maskable word RAM plus a 16-byte MMIO window (TX FIFO, status, cycle counter, scratch).
module riscv_dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  data_out_mask,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CYCLE   = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [31:0]   cycle_cnt;
    logic [31:0]   scratch;

    logic          ram_hit, mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;
    logic          empty, full, push_req, push_ok, pop, drop, ovf_clr, cyc_clr;
    logic [31:0]   status, rd_word;

    assign ram_hit  = data_adr < RAM_BYTES;
    assign mmio_hit = data_adr[31:4] == MMIO_BASE[31:4];
    assign ram_idx  = data_adr[AW+1:2];
    assign reg_sel  = data_adr[3:2];

    assign empty    = count == '0;
    assign full     = count == FIFO_FULL;
    assign pop      = !empty && tx_ready;
    assign push_req = mem_write && mmio_hit && reg_sel == REG_TXDATA && data_out_mask[0];
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign ovf_clr  = mem_write && mmio_hit && reg_sel == REG_STATUS && data_out_mask[0] && data_out[3];
    assign cyc_clr  = mem_write && mmio_hit && reg_sel == REG_CYCLE && data_out_mask != 4'b0000;
    assign status   = {28'b0, overflow, full, empty, 1'b0};

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_STATUS:  rd_word = status;
                REG_CYCLE:   rd_word = cycle_cnt;
                REG_SCRATCH: rd_word = scratch;
                default:     rd_word = '0;
            endcase
        end
    end

    assign data_in = mem_read ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (mem_write && ram_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_out_mask[i]) ram[ram_idx][8*i +: 8] <= data_out[8*i +: 8];
            end
        end
        if (push_ok) fifo_mem[wr_ptr] <= data_out[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            scratch   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + (PW + 1)'(1);
            else if (pop && !push_ok) count <= count - (PW + 1)'(1);
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            cycle_cnt <= cyc_clr ? '0 : cycle_cnt + 32'd1;
            if (mem_write && mmio_hit && reg_sel == REG_SCRATCH) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (data_out_mask[i]) scratch[8*i +: 8] <= data_out[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_mmio.sv
`timescale 1ns/1ps
// Bench for riscv_dmem_mmio: queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_riscv_dmem_mmio;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned FD    = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  mask = 4'b0000;
    logic [31:0] adr = '0;
    logic [31:0] dout = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] data_in;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int n_vec = 0;
    int n_bad = 0;

    riscv_dmem_mmio #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_out_mask(mask), .data_adr(adr), .data_out(dout), .data_in(data_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_ram [int unsigned];
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_scr = '0;
    bit          force_armed = 1'b0;

    function automatic bit in_mmio(input logic [31:0] a);
        return a >= BASE && a < BASE + 32'd16;
    endfunction

    function automatic int unsigned mmio_reg(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    // Returns 0 when the expected read value is unknown (unwritten RAM word).
    function automatic bit exp_read(output logic [31:0] v);
        int unsigned w;
        v = '0;
        if (!mem_read) return 1'b1;
        if (adr < DEPTH * 4) begin
            w = adr / 4;
            if (!m_ram.exists(w)) return 1'b0;
            v = m_ram[w];
        end else if (in_mmio(adr)) begin
            case (mmio_reg(adr))
                1: v = {28'b0, m_ovf, m_q.size() == FD, m_q.size() == 0, 1'b0};
                2: v = force_armed ? 32'hFFFF_FFFF : m_cyc;
                3: v = m_scr;
                default: v = '0;
            endcase
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int unsigned w, r, sz;
        bit pop_now, push_now;
        logic [31:0] word;
        if (!rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = '0;
            m_scr = '0;
        end else begin
            sz = m_q.size();
            pop_now = sz > 0 && tx_ready;
            push_now = mem_write && in_mmio(adr) && mmio_reg(adr) == 0 && mask[0];
            if (pop_now) void'(m_q.pop_front());
            if (push_now) begin
                if (sz < FD || pop_now) m_q.push_back(dout[7:0]);
                else m_ovf = 1'b1;
            end else if (mem_write && in_mmio(adr) && mmio_reg(adr) == 1 && mask[0] && dout[3]) begin
                m_ovf = 1'b0;
            end
            if (mem_write && in_mmio(adr) && mmio_reg(adr) == 2 && mask != 4'b0000) m_cyc = '0;
            else m_cyc = (force_armed ? 32'hFFFF_FFFF : m_cyc) + 32'd1;
            if (mem_write && in_mmio(adr) && mmio_reg(adr) == 3) begin
                for (int i = 0; i < 4; i++) if (mask[i]) m_scr[8*i +: 8] = dout[8*i +: 8];
            end
            if (mem_write && adr < DEPTH * 4 && mask != 4'b0000) begin
                w = adr / 4;
                word = m_ram.exists(w) ? m_ram[w] : 32'hxxxx_xxxx;
                for (int i = 0; i < 4; i++) if (mask[i]) word[8*i +: 8] = dout[8*i +: 8];
                m_ram[w] = word;
            end
            r = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ev;
        if (exp_read(ev)) check("model data_in", data_in, ev);
        check("model tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
        check("model tx_data", {24'b0, tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        adr = a; dout = d; mask = m; mem_write = 1'b1; mem_read = 1'b0;
        cyc();
        mem_write = 1'b0; mask = 4'b0000;
    endtask

    task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
        adr = a; mem_read = 1'b1;
        #1;
        check(nm, data_in, exp);
        mem_read = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) cyc();
        check("reset tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset tx_data", {24'b0, tx_data}, 32'h0);
        check("reset data_in idle", data_in, 32'h0);
        rd_check("reset cycle", BASE + 32'h8, 32'h0);
        rst = 1'b1;
        cyc();

        // RAM word store, lane store, empty-mask store
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        rd_check("ram full word", 32'h10, 32'hDEAD_BEEF);
        wr(32'h10, 32'h0000_5500, 4'b0010);
        rd_check("ram lane1", 32'h10, 32'hDEAD_55EF);
        wr(32'h10, 32'h0000_0000, 4'b0000);
        rd_check("ram mask0", 32'h10, 32'hDEAD_55EF);
        wr(32'h13, 32'h1122_3344, 4'b1001);
        rd_check("ram low bits ignored", 32'h10, 32'h11AD_5544);
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
        rd_check("ram top word", 32'hFFC, 32'hCAFE_F00D);

        // Fill FIFO past capacity with no consumer
        tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) wr(BASE, 32'(b), 4'b0001);
        rd_check("status full ovf", BASE + 32'h4, 32'h0000_000C);
        rd_check("txdata reads 0", BASE, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain order", {24'b0, tx_data}, 32'h41 + 32'(i));
            cyc();
        end
        check("drained tx_valid", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd_check("status empty ovf", BASE + 32'h4, 32'h0000_000A);

        // Overflow clear, then push+pop while full
        wr(BASE + 32'h4, 32'h8, 4'b0001);
        rd_check("status cleared", BASE + 32'h4, 32'h0000_0002);
        for (int b = 8'h61; b <= 8'h64; b++) wr(BASE, 32'(b), 4'b0001);
        rd_check("status full", BASE + 32'h4, 32'h0000_0004);
        tx_ready = 1'b1;
        wr(BASE, 32'h7A, 4'b0001);
        tx_ready = 1'b0;
        rd_check("full push+pop", BASE + 32'h4, 32'h0000_0004);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("last drained", {24'b0, tx_data}, 32'h7A);
        cyc();
        tx_ready = 1'b0;
        check("after last", {31'b0, tx_valid}, 32'h0);

        // Cycle counter load and wrap
        wr(BASE + 32'h8, 32'h1234_5678, 4'b0100);
        repeat (10) cyc();
        rd_check("cycle 10", BASE + 32'h8, 32'd10);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        force_armed = 1'b1;
        #1;
        release dut.cycle_cnt;
        adr = BASE + 32'h8; mem_read = 1'b1;
        #1;
        check("cycle max", data_in, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        force_armed = 1'b0;
        check("cycle wrap", data_in, 32'h0);
        mem_read = 1'b0;
        cyc();

        // Scratch and unmapped space
        wr(BASE + 32'hC, 32'h1234_5678, 4'b1111);
        wr(BASE + 32'hC, 32'hAB00_0000, 4'b1000);
        rd_check("scratch lane3", BASE + 32'hC, 32'hAB34_5678);
        wr(32'h4000_0000, 32'hFFFF_FFFF, 4'b1111);
        rd_check("unmapped read", 32'h4000_0000, 32'h0);
        rd_check("unmapped no ram change", 32'h10, 32'hDEAD_BEEF);
        rd_check("unmapped no scratch change", BASE + 32'hC, 32'hAB34_5678);

        // Reset mid-drain
        for (int b = 1; b <= 3; b++) wr(BASE, 32'(b), 4'b0001);
        tx_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async reset tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async reset tx_data", {24'b0, tx_data}, 32'h0);
        adr = BASE + 32'h4; mem_read = 1'b1;
        #1;
        check("reset status", data_in, 32'h0000_0002);
        mem_read = 1'b0;
        cyc();
        rst = 1'b1;
        tx_ready = 1'b0;
        rd_check("reset scratch", BASE + 32'hC, 32'h0);
        rd_check("ram kept", 32'h10, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
